// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised CPU core: opcodes, FSM states and
// the sign-extension helper used for jump offsets and effective addresses.
package cpu_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_JUMP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Sign-extend the low w bits of v to 32 bits.
  function automatic logic [31:0] sext(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 32; i++) begin
      if (i >= w) r[i] = v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port and
// an extra asynchronous debug read port. All registers clear on reset.
module cpu_regfile #(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     i_ra1,
  output logic [DATA_W-1:0] o_rd1,
  input  logic [AW-1:0]     i_ra2,
  output logic [DATA_W-1:0] o_rd2,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wa,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [AW-1:0]     i_dbg_a,
  output logic [DATA_W-1:0] o_dbg_d
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_we && (i_wa == AW'(i))) r_regs[i] <= i_wd;
      end
    end
  end

  assign o_rd1   = r_regs[i_ra1];
  assign o_rd2   = r_regs[i_ra2];
  assign o_dbg_d = r_regs[i_dbg_a];

endmodule

// File: rtl/param_cpu_core.sv
// Parametrised multi-cycle CPU core: IDLE/FETCH/EXEC/HALT sequencing with a
// fetch handshake, run/step control, retire counter and a debug read port.
module param_cpu_core
  import cpu_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int NUM_REGS   = 4,
  parameter  int PC_W       = 8,
  parameter  int DMEM_DEPTH = 32,
  parameter  int CNT_W      = 16,
  localparam int REG_AW     = $clog2(NUM_REGS),
  localparam int DA_W       = $clog2(DMEM_DEPTH),
  localparam int INSTR_W    = 2 + 3 * REG_AW,
  localparam int DBG_W      = (DATA_W > PC_W) ? ((DATA_W > CNT_W) ? DATA_W : CNT_W)
                                              : ((PC_W > CNT_W) ? PC_W : CNT_W)
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  input  logic [1:0]         dbg_sel,
  input  logic [DA_W-1:0]    dbg_idx,
  output logic [DBG_W-1:0]   dbg_data,
  output logic               running,
  output logic               halted,
  output logic               retire
);

  state_t               r_state, w_state_next;
  logic [PC_W-1:0]      r_pc, w_pc_next;
  logic                 r_one_shot, w_one_shot_next;
  logic [INSTR_W-1:0]   r_ir;
  logic [CNT_W-1:0]     r_count;
  logic [DATA_W-1:0]    r_dmem [DMEM_DEPTH];

  logic [1:0]           w_op;
  logic [REG_AW-1:0]    w_rs, w_rt, w_f;
  logic [3*REG_AW-1:0]  w_jofs;
  logic [PC_W-1:0]      w_jofs_ext;
  logic                 w_jump_zero;
  logic [DA_W-1:0]      w_ea;
  logic [DATA_W-1:0]    w_rd1, w_rd2, w_rf_dbg;
  logic                 w_exec;
  logic                 w_rf_we;
  logic [REG_AW-1:0]    w_rf_wa;
  logic [DATA_W-1:0]    w_rf_wd;

  assign w_op   = r_ir[INSTR_W-1 -: 2];
  assign w_rs   = r_ir[3*REG_AW-1 -: REG_AW];
  assign w_rt   = r_ir[2*REG_AW-1 -: REG_AW];
  assign w_f    = r_ir[REG_AW-1:0];
  assign w_jofs = r_ir[3*REG_AW-1:0];

  assign w_jofs_ext  = PC_W'(sext(32'(w_jofs), 3 * REG_AW));
  assign w_jump_zero = (w_jofs == '0);
  assign w_ea        = DA_W'(32'(w_rd1) + sext(32'(w_f), REG_AW));
  assign w_exec      = (r_state == ST_EXEC);

  assign w_rf_we = w_exec && ((w_op == OP_ADD) || (w_op == OP_LOAD));
  assign w_rf_wa = (w_op == OP_ADD) ? w_f : w_rt;
  assign w_rf_wd = (w_op == OP_ADD) ? (w_rd1 + w_rd2) : r_dmem[w_ea];

  cpu_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (CLK),
    .rst_n   (reset),
    .i_ra1   (w_rs),
    .o_rd1   (w_rd1),
    .i_ra2   (w_rt),
    .o_rd2   (w_rd2),
    .i_we    (w_rf_we),
    .i_wa    (w_rf_wa),
    .i_wd    (w_rf_wd),
    .i_dbg_a (dbg_idx[REG_AW-1:0]),
    .o_dbg_d (w_rf_dbg)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_one_shot <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_one_shot <= w_one_shot_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_one_shot_next = r_one_shot;
    case (r_state)
      ST_IDLE: begin
        if (run || step) w_state_next = ST_FETCH;
        if (step) w_one_shot_next = 1'b1;
      end
      ST_FETCH: begin
        if (imem_valid) w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        // A zero-offset jump is the halt idiom; the PC stays on the jump itself.
        if ((w_op == OP_JUMP) && w_jump_zero) begin
          w_state_next    = ST_HALT;
          w_one_shot_next = 1'b0;
        end else begin
          w_pc_next = (w_op == OP_JUMP) ? (r_pc + PC_W'(1) + w_jofs_ext) : (r_pc + PC_W'(1));
          if (r_one_shot || !run) begin
            w_state_next    = ST_IDLE;
            w_one_shot_next = 1'b0;
          end else begin
            w_state_next = ST_FETCH;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_ir    <= '0;
      r_count <= '0;
    end else begin
      if ((r_state == ST_FETCH) && imem_valid) r_ir <= imem_data;
      if (w_exec) r_count <= r_count + CNT_W'(1);
    end
  end

  // Data memory comes out of reset holding its own index, so it cannot map to block RAM.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) r_dmem[i] <= DATA_W'(i);
    end else if (w_exec && (w_op == OP_STORE)) begin
      r_dmem[w_ea] <= w_rd2;
    end
  end

  always_comb begin
    dbg_data = '0;
    case (dbg_sel)
      2'd0:    dbg_data = DBG_W'(r_pc);
      2'd1:    dbg_data = DBG_W'(w_rf_dbg);
      2'd2:    dbg_data = DBG_W'(r_dmem[dbg_idx]);
      default: dbg_data = DBG_W'(r_count);
    endcase
  end

  assign imem_addr = r_pc;
  assign imem_req  = (r_state == ST_FETCH);
  assign running   = (r_state == ST_FETCH) || (r_state == ST_EXEC);
  assign halted    = (r_state == ST_HALT);
  assign retire    = w_exec;

endmodule

// File: tb/tb_param_cpu_core.sv
// Self-checking bench for param_cpu_core at default parameters: directed
// scenarios plus a random single-step program against an ISA-level model.
module tb_param_cpu_core;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [7:0]  imem_data;
  logic        imem_valid = 1'b0;
  logic [1:0]  dbg_sel = 2'd0;
  logic [4:0]  dbg_idx = 5'd0;
  logic [15:0] dbg_data;
  logic        running, halted, retire;

  logic [7:0]  prog [256];
  int          n_cmp = 0;
  int          n_fail = 0;

  int m_reg [4];
  int m_dmem [32];
  int m_pc, m_cnt;
  bit m_halt;

  always #5 CLK = ~CLK;
  assign imem_data = prog[imem_addr];

  param_cpu_core dut (
    .CLK(CLK), .reset(reset), .run(run), .step(step),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_data(imem_data),
    .imem_valid(imem_valid), .dbg_sel(dbg_sel), .dbg_idx(dbg_idx),
    .dbg_data(dbg_data), .running(running), .halted(halted), .retire(retire)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dbg(input string tag, input int sel, input int idx, input int exp);
    dbg_sel = 2'(sel);
    dbg_idx = 5'(idx);
    #1;
    check(tag, 32'(dbg_data), 32'(exp));
  endtask

  function automatic logic [7:0] enc(input int op, input int rs, input int rt, input int f);
    return 8'((op << 6) | (rs << 4) | (rt << 2) | f);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    for (int i = 0; i < 32; i++) m_dmem[i] = i;
    m_pc = 0; m_cnt = 0; m_halt = 0;
  endfunction

  // One instruction at ISA level: fields, sign-extension and wrap by plain arithmetic.
  function automatic void model_exec();
    int ins, op, rs, rt, f, sf, v, ofs, ea, sum;
    ins = int'(prog[m_pc]);
    op = (ins >> 6) & 3; rs = (ins >> 4) & 3; rt = (ins >> 2) & 3; f = ins & 3;
    sf = (f >= 2) ? f - 4 : f;
    v = ins & 63;
    ofs = (v >= 32) ? v - 64 : v;
    ea = (m_reg[rs] + sf) & 31;
    m_cnt = (m_cnt + 1) % 65536;
    case (op)
      0: begin sum = (m_reg[rs] + m_reg[rt]) % 256; m_reg[f] = sum; m_pc = (m_pc + 1) % 256; end
      1: begin m_reg[rt] = m_dmem[ea]; m_pc = (m_pc + 1) % 256; end
      2: begin m_dmem[ea] = m_reg[rt]; m_pc = (m_pc + 1) % 256; end
      default: begin
        if (ofs == 0) m_halt = 1;
        else m_pc = (m_pc + 1 + ofs + 256) % 256;
      end
    endcase
  endfunction

  task automatic do_reset();
    run = 1'b0; step = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    #1;
    check("rst_imem_req", 32'(imem_req), 0);
    check("rst_retire", 32'(retire), 0);
    check("rst_halted", 32'(halted), 0);
    @(negedge CLK);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
  endtask

  task automatic step_wait(input bit rv);
    bit ok;
    ok = 0;
    @(negedge CLK);
    step = 1'b1;
    imem_valid = rv ? ($urandom_range(0, 2) != 0) : 1'b1;
    @(negedge CLK);
    step = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (retire) begin ok = 1; break; end
      if (rv) imem_valid = ($urandom_range(0, 2) != 0);
      @(negedge CLK);
    end
    check("step_retire_seen", 32'(ok), 1);
    @(negedge CLK);
    check("step_back_idle", 32'(running), 0);
    check("step_no_extra_retire", 32'(retire), 0);
  endtask

  task automatic run_to_halt(output int cycles);
    cycles = -1;
    @(negedge CLK);
    imem_valid = 1'b1;
    run = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge CLK);
      if (halted) begin cycles = k; break; end
    end
    check("halt_reached", 32'(cycles > 0), 1);
  endtask

  initial begin
    int cyc, rcount;

    clear_prog();
    do_reset();
    chk_dbg("reset_pc", 0, 0, 0);
    chk_dbg("reset_count", 3, 0, 0);
    for (int i = 0; i < 4; i++) chk_dbg("reset_reg", 1, i, 0);
    for (int i = 0; i < 32; i++) chk_dbg("reset_dmem", 2, i, i);

    // Scenario 1: free-run program ending in a halt.
    clear_prog();
    prog[0] = enc(1, 0, 1, 1);
    prog[1] = enc(0, 1, 1, 2);
    prog[2] = enc(2, 0, 2, 1);
    prog[3] = enc(3, 0, 0, 0);
    do_reset();
    run_to_halt(cyc);
    $display("T1 run program: halted after %0d cycles", cyc);
    check("t1_latency", 32'(cyc), 9);
    chk_dbg("t1_r1", 1, 1, 1);
    chk_dbg("t1_r2", 1, 2, 2);
    chk_dbg("t1_dmem1", 2, 1, 2);
    chk_dbg("t1_count", 3, 0, 4);
    chk_dbg("t1_pc", 0, 0, 3);
    run = 1'b0;

    // Scenario 2: stalled fetch.
    clear_prog();
    for (int i = 0; i < 8; i++) prog[i] = enc(0, 1, 1, 1);
    do_reset();
    imem_valid = 1'b0;
    @(negedge CLK); step = 1'b1;
    @(negedge CLK); step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_req_held", 32'(imem_req), 1);
      check("t2_addr_stable", 32'(imem_addr), 0);
      check("t2_no_retire", 32'(retire), 0);
      @(negedge CLK);
    end
    imem_valid = 1'b1;
    rcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (retire) rcount++;
    end
    $display("T2 stalled fetch: %0d retires after valid", rcount);
    check("t2_one_retire", 32'(rcount), 1);
    chk_dbg("t2_pc", 0, 0, 1);

    // Scenario 3: three single steps.
    clear_prog();
    prog[0] = enc(1, 0, 1, 1);
    prog[1] = enc(0, 1, 1, 2);
    prog[2] = enc(0, 2, 1, 3);
    do_reset();
    for (int s = 0; s < 3; s++) begin
      step_wait(1'b0);
      model_exec();
      $display("T3 step %0d: pc model %0d", s, m_pc);
      chk_dbg("t3_pc", 0, 0, m_pc);
    end
    chk_dbg("t3_count", 3, 0, 3);
    chk_dbg("t3_r3", 1, 3, 3);

    // Scenario 4: backward jump wrap, then ADD overflow.
    clear_prog();
    prog[0] = enc(3, 3, 3, 2);
    do_reset();
    step_wait(1'b0);
    $display("T4 jump -2 from pc 0");
    chk_dbg("t4_pc_wrap", 0, 0, 255);

    clear_prog();
    prog[0]  = enc(1, 0, 1, 1);
    prog[1]  = enc(0, 1, 1, 2);
    prog[2]  = enc(0, 2, 1, 2);
    prog[3]  = enc(0, 2, 2, 2);
    prog[4]  = enc(0, 2, 2, 2);
    prog[5]  = enc(0, 2, 2, 2);
    prog[6]  = enc(0, 2, 1, 2);
    prog[7]  = enc(0, 2, 2, 2);
    prog[8]  = enc(0, 2, 2, 2);
    prog[9]  = enc(0, 2, 2, 3);
    prog[10] = enc(0, 3, 2, 0);
    prog[11] = enc(3, 0, 0, 0);
    do_reset();
    run_to_halt(cyc);
    $display("T4 add chain halted after %0d cycles", cyc);
    chk_dbg("t4_r2_100", 1, 2, 100);
    chk_dbg("t4_r3_200", 1, 3, 200);
    chk_dbg("t4_r0_sum_wrap", 1, 0, 44);
    chk_dbg("t4_pc", 0, 0, 11);

    // Scenario 6: HALT is sticky (still halted from the add chain).
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      step = 1'($urandom_range(0, 1));
      run = 1'($urandom_range(0, 1));
      #1;
      check("t6_halted", 32'(halted), 1);
      check("t6_no_retire", 32'(retire), 0);
    end
    step = 1'b0; run = 1'b0;
    chk_dbg("t6_count", 3, 0, 12);
    $display("T6 halt sticky checked");

    // Scenario 5: reset mid-FETCH and mid-EXEC.
    clear_prog();
    prog[0] = enc(2, 0, 0, 1);
    do_reset();
    imem_valid = 1'b0;
    @(negedge CLK); run = 1'b1;
    @(negedge CLK);
    check("t5_in_fetch", 32'(imem_req), 1);
    #2 reset = 1'b0;
    #1;
    check("t5_fetch_rst_req", 32'(imem_req), 0);
    check("t5_fetch_rst_running", 32'(running), 0);
    run = 1'b0;
    @(negedge CLK); reset = 1'b1;
    imem_valid = 1'b1;
    @(negedge CLK); run = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("t5_in_exec", 32'(retire), 1);
    #1 reset = 1'b0;
    #1;
    check("t5_exec_rst_retire", 32'(retire), 0);
    check("t5_exec_rst_running", 32'(running), 0);
    run = 1'b0;
    @(negedge CLK); reset = 1'b1;
    @(negedge CLK);
    chk_dbg("t5_dmem1_kept", 2, 1, 1);
    chk_dbg("t5_dmem5", 2, 5, 5);
    chk_dbg("t5_count", 3, 0, 0);
    chk_dbg("t5_pc", 0, 0, 0);
    $display("T5 reset during fetch and exec");

    // Random program, single-stepped with random fetch stalls.
    for (int i = 0; i < 256; i++) prog[i] = 8'($urandom_range(0, 255));
    do_reset();
    for (int s = 0; s < 80; s++) begin
      if (m_halt) break;
      step_wait(1'b1);
      model_exec();
      $display("R step %0d: instr %02h pc model %0d", s, prog[(m_pc + 255) % 256], m_pc);
      check("rnd_halted", 32'(halted), 32'(m_halt));
      chk_dbg("rnd_pc", 0, 0, m_pc);
      chk_dbg("rnd_count", 3, 0, m_cnt);
    end
    for (int i = 0; i < 4; i++) chk_dbg("rnd_reg", 1, i, m_reg[i]);
    for (int i = 0; i < 32; i++) chk_dbg("rnd_dmem", 2, i, m_dmem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
